// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types and constants for the two-digit segment scanner.
//   scan_state_t : scan FSM states in cyclic order
//   AN_*         : active-low anode patterns (an[0] = ones, an[1] = tens)
//   max_int      : constant-foldable max, used to size the slot counter
package seg_scan_pkg;

  typedef enum logic [1:0] {
    S_DEAD0 = 2'd0,
    S_ONES  = 2'd1,
    S_DEAD1 = 2'd2,
    S_TENS  = 2'd3
  } scan_state_t;

  localparam logic [1:0] AN_OFF  = 2'b11;
  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg_scan_mux_timer.sv
// scan_slot_timer: counts the cycles of the current scan slot.
//   clk, rst  : clock, async active-high reset
//   limit     : slot length in cycles for the current state (>= 1)
//   cnt       : registered position within the slot, 0..limit-1
//   slot_done : high in the last cycle of the slot; cnt wraps to 0 on the next edge
module scan_slot_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW:0]   limit,
  output logic [CW-1:0] cnt,
  output logic          slot_done
);

  assign slot_done = ({1'b0, cnt} == (limit - (CW+1)'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            cnt <= '0;
    else if (slot_done) cnt <= '0;
    else                cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexes the ones/tens 7-segment patterns onto a shared
// segment bus with blanking dead time between digits.
//   clk, rst   : clock, async active-high reset
//   en         : display enable (0 blanks outputs; scan timing keeps running)
//   ones_seg   : decoded ones pattern
//   tens_seg   : decoded tens pattern
//   tens_bcd   : BCD tens value (only used with LEAD_ZERO_BLANK_EN)
//   seg        : shared segment bus (registered)
//   an         : active-low digit enables, an[0] = ones, an[1] = tens (registered)
//   frame_tick : one-cycle pulse in the first S_ONES cycle of each frame
// Build option: define LEAD_ZERO_BLANK_EN to blank a leading zero in the tens digit.
module seg_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int         REFRESH_DIV = 50000,
  parameter int         DEAD_CYC    = 16,
  parameter logic [6:0] SEG_BLANK   = 7'b1111111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] ones_seg,
  input  logic [6:0] tens_seg,
  input  logic [3:0] tens_bcd,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int CW = $clog2(max_int(REFRESH_DIV, DEAD_CYC));
  localparam logic [CW:0] LIM_DIG  = (CW+1)'(REFRESH_DIV);
  localparam logic [CW:0] LIM_DEAD = (CW+1)'(DEAD_CYC);

  scan_state_t state, state_nxt;
  logic [6:0]  snap_ones, snap_tens, snap_ones_nxt, snap_tens_nxt;
  logic [6:0]  seg_nxt;
  logic [1:0]  an_nxt;
  logic [CW:0] limit;
  logic [CW-1:0] cnt;
  logic        slot_done, capture;

  assign limit = (state == S_ONES || state == S_TENS) ? LIM_DIG : LIM_DEAD;

  scan_slot_timer #(.CW(CW)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .limit     (limit),
    .cnt       (cnt),
    .slot_done (slot_done)
  );

  // Slot position is only observed for debug; the FSM needs just slot_done.
  logic unused_cnt;
  assign unused_cnt = ^cnt;

`ifndef LEAD_ZERO_BLANK_EN
  logic unused_bcd;
  assign unused_bcd = ^tens_bcd;
`endif

  // Snapshot on the DEAD0 -> ONES edge so a mid-frame count change never tears.
  assign capture = slot_done && (state == S_DEAD0);

  always_comb begin
    state_nxt = state;
    if (slot_done) begin
      case (state)
        S_DEAD0: state_nxt = S_ONES;
        S_ONES:  state_nxt = S_DEAD1;
        S_DEAD1: state_nxt = S_TENS;
        default: state_nxt = S_DEAD0;
      endcase
    end

    snap_ones_nxt = snap_ones;
    snap_tens_nxt = snap_tens;
    if (capture) begin
      snap_ones_nxt = ones_seg;
`ifdef LEAD_ZERO_BLANK_EN
      snap_tens_nxt = (tens_bcd == 4'd0) ? SEG_BLANK : tens_seg;
`else
      snap_tens_nxt = tens_seg;
`endif
    end

    // Outputs are decoded from next-state values and registered, so they line
    // up with the state register and have no combinational input path.
    seg_nxt = SEG_BLANK;
    an_nxt  = AN_OFF;
    if (en) begin
      case (state_nxt)
        S_ONES: begin seg_nxt = snap_ones_nxt; an_nxt = AN_ONES; end
        S_TENS: begin seg_nxt = snap_tens_nxt; an_nxt = AN_TENS; end
        default: begin seg_nxt = SEG_BLANK; an_nxt = AN_OFF; end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_DEAD0;
      snap_ones  <= SEG_BLANK;
      snap_tens  <= SEG_BLANK;
      seg        <= SEG_BLANK;
      an         <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      snap_ones  <= snap_ones_nxt;
      snap_tens  <= snap_tens_nxt;
      seg        <= seg_nxt;
      an         <= an_nxt;
      frame_tick <= capture;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: directed bench for seg_scan_mux with REFRESH_DIV=4,
// DEAD_CYC=2 (12-cycle frame). Frame phases: 0-1 dead, 2-5 ones, 6-7 dead,
// 8-11 tens; frame_tick at phase 2. Cycle 0 is the cycle right after reset release.
module tb_seg_scan_mux;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [6:0] ones_seg = 7'h40;
  logic [6:0] tens_seg = 7'h79;
  logic [3:0] tens_bcd = 4'd0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_tick;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  seg_scan_mux #(.REFRESH_DIV(4), .DEAD_CYC(2), .SEG_BLANK(7'h7F)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ones_seg   (ones_seg),
    .tens_seg   (tens_seg),
    .tens_bcd   (tens_bcd),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Expected display for the current frame phase; blank models en=0 windows.
  task automatic chk_phase(input logic [6:0] o, input logic [6:0] t, input logic blank);
    int p;
    logic [1:0] a_e;
    logic [6:0] s_e;
    p   = cyc % 12;
    a_e = 2'b11;
    s_e = 7'h7F;
    if (!blank) begin
      if (p >= 2 && p <= 5)  begin a_e = 2'b10; s_e = o; end
      if (p >= 8 && p <= 11) begin a_e = 2'b01; s_e = t; end
    end
    chk("an", {6'd0, an}, {6'd0, a_e});
    chk("seg", {1'b0, seg}, {1'b0, s_e});
    chk("frame_tick", {7'd0, frame_tick}, {7'd0, (p == 2)});
  endtask

  // Pulse reset at a negedge, check async blanking, release, check cycle 0.
  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async_an", {6'd0, an}, 8'h03);
    chk("rst_async_seg", {1'b0, seg}, 8'h7F);
    chk("rst_async_tick", {7'd0, frame_tick}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    #1;
  endtask

  logic [6:0] t_zero;

  initial begin
`ifdef LEAD_ZERO_BLANK_EN
    t_zero = 7'h7F;
`else
    t_zero = 7'h79;
`endif
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_an", {6'd0, an}, 8'h03);
    chk("reset_seg", {1'b0, seg}, 8'h7F);
    chk("reset_tick", {7'd0, frame_tick}, 8'h00);
    rst = 1'b0;
    cyc = 0;
    #1;
    chk_phase(7'h40, t_zero, 1'b0);

    // Basic scan, mid-frame input changes, en drop inside S_ONES
    while (cyc < 57) begin
      step();
      chk_phase((cyc >= 26) ? 7'h24 : 7'h40,
                (cyc >= 44) ? 7'h12 : t_zero,
                (cyc >= 39 && cyc <= 43));
      if (cyc == 20) ones_seg = 7'h24;
      if (cyc == 26) tens_seg = 7'h12;
      if (cyc == 38) en = 1'b0;
      if (cyc == 43) en = 1'b1;
    end

    // Reset mid S_TENS (cycle 57 is phase 9); tens_bcd=0 so 12 may be blanked
`ifdef LEAD_ZERO_BLANK_EN
    t_zero = 7'h7F;
`else
    t_zero = 7'h12;
`endif
    reset_pulse();
    chk_phase(7'h24, t_zero, 1'b0);
    while (cyc < 14) begin
      step();
      chk_phase(7'h24, t_zero, 1'b0);
    end

    // Nonzero tens_bcd always passes tens_seg through
    tens_bcd = 4'd3;
    tens_seg = 7'h30;
    ones_seg = 7'h19;
    reset_pulse();
    chk_phase(7'h19, 7'h30, 1'b0);
    while (cyc < 24) begin
      step();
      chk_phase(7'h19, 7'h30, 1'b0);
    end

    // Random inputs and en: never both anodes low
    for (int i = 0; i < 12000; i++) begin
      ones_seg = 7'($urandom);
      tens_seg = 7'($urandom);
      tens_bcd = 4'($urandom_range(0, 9));
      en       = 1'($urandom);
      step();
      n_assert++;
      assert (an !== 2'b00) else begin
        n_fail++;
        $error("FAIL an_exclusive cyc=%0d observed=%b expected=not 00", cyc, an);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
